vedic_mul_iterative: RTL and testbench

//  Sequential, parametrised successor to the combinational vedic combine stage.
//  - Multiplies two MUL_Size-bit operands using one (MUL_Size/2)x(MUL_Size/2) core, time-shared over 4 cycles.
//  - Partial products are combined Vedic-style in a 2*MUL_Size accumulator.
//  - Sits between operand producers and result consumers; valid/ready handshake on both sides.

---
 rtl/vedic_pkg.sv | 23 ++
 rtl/vedic_half_mul.sv | 12 +
 rtl/vedic_mul_iterative.sv | 154 +++++++++++++++
 tb/tb_vedic_mul_iterative.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared state encodings, phase constants and width helpers for the iterative vedic multiplier.
package vedic_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t MUL  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef logic [1:0] phase_t;
    localparam phase_t PH_LL = 2'd0;
    localparam phase_t PH_HL = 2'd1;
    localparam phase_t PH_LH = 2'd2;
    localparam phase_t PH_HH = 2'd3;

    function automatic int half_width(input int n);
        return n / 2;
    endfunction

    function automatic int product_width(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/vedic_half_mul.sv
// Combinational H x H -> 2H unsigned multiplier core, time-shared by vedic_mul_iterative.
module vedic_half_mul #(
    parameter int H = 4
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-1:0] p
);

    assign p = (2*H)'(x) * (2*H)'(y);

endmodule

// File: rtl/vedic_mul_iterative.sv
// Iterative Vedic multiplier: one half-width core over 4 phases, valid/ready on both sides.
// Optional signed operation is enabled by defining VEDIC_MUL_SIGNED_EN.
module vedic_mul_iterative
    import vedic_pkg::*;
#(
    parameter int MUL_Size        = 8,
    parameter int Added_Zeros     = half_width(MUL_Size),
    parameter int Mul_Output_Size = product_width(MUL_Size)
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef VEDIC_MUL_SIGNED_EN
    input  logic                       signed_mode,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MUL_Size-1:0]        a,
    input  logic [MUL_Size-1:0]        b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Mul_Output_Size-1:0] product,
    output logic                       busy
);

    state_t                       state;
    phase_t                       phase;
    logic [MUL_Size-1:0]          a_reg;
    logic [MUL_Size-1:0]          b_reg;
    logic [Mul_Output_Size-1:0]   acc;
    logic                         neg;

    logic [MUL_Size-1:0]          a_mag;
    logic [MUL_Size-1:0]          b_mag;
    logic                         neg_in;
    logic                         accept;

    logic [Added_Zeros-1:0]       core_x;
    logic [Added_Zeros-1:0]       core_y;
    logic [2*Added_Zeros-1:0]     core_p;
    logic [Mul_Output_Size-1:0]   pp_ext;
    logic [Mul_Output_Size-1:0]   term;
    logic [Mul_Output_Size-1:0]   acc_next;
    logic [Mul_Output_Size-1:0]   final_value;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);

    // The core always sees unsigned magnitudes; the sign is reapplied once at the end.
`ifdef VEDIC_MUL_SIGNED_EN
    always_comb begin
        a_mag  = a;
        b_mag  = b;
        neg_in = 1'b0;
        if (signed_mode) begin
            if (a[MUL_Size-1]) a_mag = ~a + MUL_Size'(1);
            if (b[MUL_Size-1]) b_mag = ~b + MUL_Size'(1);
            neg_in = a[MUL_Size-1] ^ b[MUL_Size-1];
        end
    end
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign neg_in = 1'b0;
`endif

    always_comb begin
        core_x = a_reg[Added_Zeros-1:0];
        core_y = b_reg[Added_Zeros-1:0];
        case (phase)
            PH_LL: begin
                core_x = a_reg[Added_Zeros-1:0];
                core_y = b_reg[Added_Zeros-1:0];
            end
            PH_HL: begin
                core_x = a_reg[MUL_Size-1:Added_Zeros];
                core_y = b_reg[Added_Zeros-1:0];
            end
            PH_LH: begin
                core_x = a_reg[Added_Zeros-1:0];
                core_y = b_reg[MUL_Size-1:Added_Zeros];
            end
            default: begin
                core_x = a_reg[MUL_Size-1:Added_Zeros];
                core_y = b_reg[MUL_Size-1:Added_Zeros];
            end
        endcase
    end

    vedic_half_mul #(
        .H(Added_Zeros)
    ) u_core (
        .x(core_x),
        .y(core_y),
        .p(core_p)
    );

    assign pp_ext = Mul_Output_Size'(core_p);

    always_comb begin
        term = pp_ext;
        case (phase)
            PH_LL:   term = pp_ext;
            PH_HL:   term = pp_ext << Added_Zeros;
            PH_LH:   term = pp_ext << Added_Zeros;
            default: term = pp_ext << (2 * Added_Zeros);
        endcase
    end

    assign acc_next    = acc + term;
    assign final_value = neg ? (~acc_next + Mul_Output_Size'(1)) : acc_next;

    // product is only written on ph3 completion so it stays stable through DONE and afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= PH_LL;
            acc     <= '0;
            product <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                        neg   <= neg_in;
                        acc   <= '0;
                        phase <= PH_LL;
                        state <= MUL;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    phase <= phase + 2'd1;
                    if (phase == PH_HH) begin
                        product <= final_value;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= PH_LL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mul_iterative.sv
// Self-checking bench for vedic_mul_iterative (MUL_Size=8); signed cases run when VEDIC_MUL_SIGNED_EN is defined.
module tb_vedic_mul_iterative;

    logic        clk;
    logic        rst;
    logic        signed_mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int errors = 0;
    int checks = 0;

    vedic_mul_iterative #(
        .MUL_Size(8)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VEDIC_MUL_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiplication, sign-extended operands when signed.
    function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y, input logic sm);
        int sx;
        int sy;
        int p;
        if (sm) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        p = sx * sy;
        return p[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents operands and returns at the negedge after the accepting clock edge.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic sm, input logic keep_valid);
        int waited;
        waited = 0;
        a = x;
        b = y;
        signed_mode = sm;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) checkOutput("accept_timeout", 32'(waited), 32'd0);
        @(negedge clk);
        if (!keep_valid) begin
            in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            signed_mode = 1'($urandom);
        end
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] x, input logic [7:0] y, input logic sm);
        int lat;
        applyStimulus(x, y, sm, 1'b0);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_product"}, {16'd0, product}, {16'd0, refProduct(x, y, sm)});
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [7:0] rx;
        logic [7:0] ry;
        logic rs;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_product", {16'd0, product}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] basic 13*11");
        applyStimulus(8'd13, 8'd11, 1'b0, 1'b0);
        checkOutput("mul_busy", {31'd0, busy}, 32'd1);
        checkOutput("mul_in_ready", {31'd0, in_ready}, 32'd0);
        waitResult(lat);
        checkOutput("t1_latency", 32'(lat), 32'd4);
        checkOutput("t1_product", {16'd0, product}, 32'h008F);
        checkOutput("t1_done_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("t1_in_ready_after", {31'd0, in_ready}, 32'd1);
        checkOutput("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);
        checkOutput("t1_product_kept", {16'd0, product}, 32'h008F);

        $display("[TB] boundary operands");
        runOp("max", 8'hFF, 8'hFF, 1'b0);
        checkOutput("max_const", {16'd0, product}, 32'hFE01);
        runOp("zero", 8'h00, 8'hA5, 1'b0);

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(8'd13, 8'd11, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_product", {16'd0, product}, 32'h008F);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] back-to-back");
        applyStimulus(8'd3, 8'd4, 1'b0, 1'b1);
        a = 8'd200;
        b = 8'd2;
        waitResult(lat);
        checkOutput("b2b_first_latency", 32'(lat), 32'd4);
        checkOutput("b2b_first_product", {16'd0, product}, 32'h000C);
        checkOutput("b2b_done_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b_second_busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b_valid_dropped", {31'd0, out_valid}, 32'd0);
        waitResult(lat);
        checkOutput("b2b_second_latency", 32'(lat), 32'd4);
        checkOutput("b2b_second_product", {16'd0, product}, 32'h0190);
        @(negedge clk);

        $display("[TB] async reset mid-operation");
        applyStimulus(8'd100, 8'd100, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_product", {16'd0, product}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        runOp("post_rst", 8'd7, 8'd9, 1'b0);
        checkOutput("post_rst_const", {16'd0, product}, 32'h003F);

`ifdef VEDIC_MUL_SIGNED_EN
        $display("[TB] signed mode");
        runOp("s_m128sq", 8'h80, 8'h80, 1'b1);
        checkOutput("s_m128sq_const", {16'd0, product}, 32'h4000);
        runOp("s_m3x5", 8'hFD, 8'd5, 1'b1);
        checkOutput("s_m3x5_const", {16'd0, product}, 32'hFFF1);
        runOp("s_127xm1", 8'd127, 8'hFF, 1'b1);
        checkOutput("s_127xm1_const", {16'd0, product}, 32'hFF81);
        runOp("s_unsigned", 8'hFD, 8'd5, 1'b0);
        checkOutput("s_unsigned_const", {16'd0, product}, 32'h04F1);
`endif

        $display("[TB] random operations");
        for (int i = 0; i < 30; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
`ifdef VEDIC_MUL_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            runOp("rand", rx, ry, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
